tpg_multi: RTL

//  Parametrised test-pattern generator: programmable raster timing plus selectable pattern (solid, ramps, bars, checker).

---
 rtl/tpg_multi_if.sv | 15 +
 rtl/tpg_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpg_multi_if.sv
// Video output bundle of tpg_multi: syncs, data-valid, frame/line markers and pixel.
interface tpg_multi_if #(
  parameter int PW  = 8,
  parameter int NCH = 3
);
  logic                hs;
  logic                vs;
  logic                de;
  logic                sof;
  logic                eol;
  logic [NCH*PW-1:0]   pix;

  modport master (output hs, vs, de, sof, eol, pix);
  modport slave  (input  hs, vs, de, sof, eol, pix);
endinterface

// File: rtl/tpg_multi.sv
// Programmable raster test-pattern generator (solid, h/v ramp, colour bars, checker).
// Optional TPG_MOTION_EN: ramps, bars and checker scroll by frame_cnt.
module tpg_multi #(
  parameter int PW     = 8,
  parameter int NCH    = 3,
  parameter int H_BITS = 12,
  parameter int V_BITS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [NCH*PW-1:0] solid_color,
  input  logic [H_BITS-1:0] h_total,
  input  logic [H_BITS-1:0] hs_start,
  input  logic [H_BITS-1:0] hs_end,
  input  logic [H_BITS-1:0] h_act_start,
  input  logic [H_BITS-1:0] h_act_end,
  input  logic [V_BITS-1:0] v_total,
  input  logic [V_BITS-1:0] vs_start,
  input  logic [V_BITS-1:0] vs_end,
  input  logic [V_BITS-1:0] v_act_start,
  input  logic [V_BITS-1:0] v_act_end,
  input  logic [H_BITS-1:0] bar_w,
  input  logic [3:0]        chk_log2,
  input  logic              hs_pol,
  input  logic              vs_pol,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  tpg_multi_if.master       vid
);

  localparam int TW = H_BITS + 3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_reg, state_next;
  logic [H_BITS-1:0]   x_reg, x_next;
  logic [V_BITS-1:0]   y_reg, y_next;
  logic                load;
  logic                frame_end;
  logic [15:0]         fc_reg;

  logic [H_BITS-1:0]   ht_sh, hs0_sh, hs1_sh, ha0_sh, ha1_sh, bw_sh;
  logic [V_BITS-1:0]   vt_sh, vs0_sh, vs1_sh, va0_sh, va1_sh;
  logic [2:0]          mode_sh;
  logic [NCH*PW-1:0]   solid_sh;
  logic [3:0]          chk_sh;

  logic                hs_act_reg, vs_act_reg, de_reg, sof_reg, eol_reg;
  logic [NCH*PW-1:0]   pix_reg;

  // ---------------- FSM and raster counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      fc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      if (frame_end)
        fc_reg <= fc_reg + 16'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    load       = 1'b0;
    frame_end  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          load       = 1'b1;
          x_next     = '0;
          y_next     = '0;
        end
      end
      RUN: begin
        if (x_reg == ht_sh - H_BITS'(1)) begin
          x_next = '0;
          if (y_reg == vt_sh - V_BITS'(1)) begin
            y_next    = '0;
            frame_end = 1'b1;
            if (en)
              load = 1'b1;
            else
              state_next = IDLE;
          end else begin
            y_next = y_reg + V_BITS'(1);
          end
        end else begin
          x_next = x_reg + H_BITS'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame configuration is frozen at every frame start so mid-frame writes land next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ht_sh    <= '0; hs0_sh <= '0; hs1_sh <= '0; ha0_sh <= '0; ha1_sh <= '0; bw_sh <= '0;
      vt_sh    <= '0; vs0_sh <= '0; vs1_sh <= '0; va0_sh <= '0; va1_sh <= '0;
      mode_sh  <= '0;
      solid_sh <= '0;
      chk_sh   <= '0;
    end else if (load) begin
      ht_sh    <= h_total;  hs0_sh <= hs_start; hs1_sh <= hs_end;
      ha0_sh   <= h_act_start; ha1_sh <= h_act_end; bw_sh <= bar_w;
      vt_sh    <= v_total;  vs0_sh <= vs_start; vs1_sh <= vs_end;
      va0_sh   <= v_act_start; va1_sh <= v_act_end;
      mode_sh  <= mode;
      solid_sh <= solid_color;
      chk_sh   <= chk_log2;
    end
  end

  // ---------------- position decode ----------------
  logic              run;
  logic              in_h, in_v, de_n, hs_n, vs_n, sof_n, eol_n;
  logic [H_BITS-1:0] ax, px;
  logic [V_BITS-1:0] ay;
  logic [PW-1:0]     fc;

  assign run   = (state_reg == RUN);
  assign in_h  = (x_reg >= ha0_sh) && (x_reg < ha1_sh);
  assign in_v  = (y_reg >= va0_sh) && (y_reg < va1_sh);
  assign de_n  = run && in_h && in_v;
  assign hs_n  = run && (x_reg >= hs0_sh) && (x_reg < hs1_sh);
  assign vs_n  = run && (y_reg >= vs0_sh) && (y_reg < vs1_sh);
  assign sof_n = de_n && (x_reg == ha0_sh) && (y_reg == va0_sh);
  // The active window may run past the line end; the line's last clock then closes it.
  assign eol_n = de_n && ((x_reg == ha1_sh - H_BITS'(1)) || (x_reg == ht_sh - H_BITS'(1)));

  assign ax = x_reg - ha0_sh;
  assign ay = y_reg - va0_sh;

`ifdef TPG_MOTION_EN
  assign fc = fc_reg[PW-1:0];
`else
  assign fc = '0;
`endif

  assign px = ax + H_BITS'(fc);

  // ---------------- pattern generation ----------------
  logic [H_BITS-1:0] bw_eff;
  logic [6:0]        bar_past;
  logic [2:0]        bar_idx;
  logic [2:0]        bar_code;
  logic              chk_x, chk_y, chk_on;
  logic [PW-1:0]     hr_v, vr_v;
  logic [NCH*PW-1:0] hramp_pix, vramp_pix, bar_pix, pat;

  assign bw_eff = (bw_sh == '0) ? H_BITS'(1) : bw_sh;

  genvar gi;
  // Bar index = number of bar boundaries k*bar_w already passed, capped at 7 by construction.
  for (gi = 0; gi < 7; gi++) begin : g_bar
    assign bar_past[gi] = TW'(px) >= (TW'(gi + 1) * TW'(bw_eff));
  end

  always_comb begin
    bar_idx = '0;
    for (int i = 0; i < 7; i++)
      bar_idx = bar_idx + {2'b00, bar_past[i]};
  end

  assign bar_code = ~bar_idx;

  assign chk_x  = |(px & (H_BITS'(1) << chk_sh));
  assign chk_y  = |(ay & (V_BITS'(1) << chk_sh));
  assign chk_on = ({28'd0, chk_sh} < 32'(H_BITS)) && (chk_x ^ chk_y);

  assign hr_v = PW'(px);
  assign vr_v = PW'(ay) + fc;

  for (gi = 0; gi < NCH; gi++) begin : g_ch
    assign hramp_pix[gi*PW +: PW] = hr_v;
    assign vramp_pix[gi*PW +: PW] = vr_v;
    if (gi < 3) begin : g_rgb
      assign bar_pix[gi*PW +: PW] = {PW{bar_code[2-gi]}};
    end else begin : g_extra
      assign bar_pix[gi*PW +: PW] = '0;
    end
  end

  always_comb begin
    pat = '0;
    case (mode_sh)
      3'd0:    pat = solid_sh;
      3'd1:    pat = hramp_pix;
      3'd2:    pat = vramp_pix;
      3'd3:    pat = bar_pix;
      3'd4:    pat = chk_on ? solid_sh : '0;
      default: pat = '0;
    endcase
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_act_reg <= 1'b0;
      vs_act_reg <= 1'b0;
      de_reg     <= 1'b0;
      sof_reg    <= 1'b0;
      eol_reg    <= 1'b0;
      pix_reg    <= '0;
    end else begin
      hs_act_reg <= hs_n;
      vs_act_reg <= vs_n;
      de_reg     <= de_n;
      sof_reg    <= sof_n;
      eol_reg    <= eol_n;
      pix_reg    <= de_n ? pat : '0;
    end
  end

  // Polarity is applied after the register so it follows the live inputs.
  assign vid.hs    = ~(hs_act_reg ^ hs_pol);
  assign vid.vs    = ~(vs_act_reg ^ vs_pol);
  assign vid.de    = de_reg;
  assign vid.sof   = sof_reg;
  assign vid.eol   = eol_reg;
  assign vid.pix   = pix_reg;
  assign busy      = run;
  assign frame_cnt = fc_reg;

endmodule
